// File: rtl/jpeg_out_pkg.sv
// Shared types, marker bytes and byte-slicing helpers for the JPEG output stage.
package jpeg_out_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_STREAM,
      ST_TAIL,
      ST_EOI_FF,
      ST_EOI_D9
   } jpeg_out_state_t;

   localparam logic [7:0] MRK_FF   = 8'hFF;
   localparam logic [7:0] MRK_EOI  = 8'hD9;
   localparam logic [7:0] STUFF_00 = 8'h00;

   // Byte idx of a 32-bit word, idx 0 being the most significant byte.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   // Keep the top valid_bits bits of b and force the rest to 1 (valid_bits in 1..8).
   function automatic logic [7:0] tail_pad(input logic [7:0] b, input logic [4:0] valid_bits);
      return b | (8'hFF >> valid_bits);
   endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous 32-bit word FIFO with full/empty flags and a synchronous clear.
// Read data is the head entry, available combinationally (show-ahead).
module jpeg_word_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic [31:0] wdata,
   input  logic        pop,
   output logic [31:0] rdata,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        wr_en;
   logic        rd_en;

   // A push while full is still accepted when the head is leaving in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   // Storage array; the head slot is read before this edge overwrites it.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= wdata;
   end

   // Read/write pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clr) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/jpeg_stream_ctrl.sv
// JPEG output sequencer: header ROM bytes, buffered bitstream words, padded
// tail, then the EOI marker, all on one registered valid/ready byte port.
module jpeg_stream_ctrl
   import jpeg_out_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int HDR_LEN    = 623,
   parameter int HDR_AW     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       JPEG_bitstream,
   input  logic              data_ready,
   input  logic              eof_data_partial_ready,
   input  logic [4:0]        end_of_file_bitstream_count,
   output logic [HDR_AW-1:0] hdr_addr,
   input  logic [7:0]        hdr_data,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HDR_LEN - 1);

   jpeg_out_state_t state, state_nx;

   logic [HDR_AW-1:0] hdr_addr_nx;
   logic [1:0]        sel, sel_nx;
   logic [31:0]       cur_word;
   logic [2:0]        tail_idx, tail_idx_nx;
   logic              stuff_pend, stuff_pend_nx;
   logic              d9_loaded, d9_nx;
   logic              done_nx;

   logic [31:0]       tail_word;
   logic [4:0]        tail_n;
   logic              eof_seen;

   logic              out_free;
   logic              load;
   logic [7:0]        load_byte;
   logic              pop;
   logic              start_acc;
   logic              capture_en;

   logic              fifo_push;
   logic [31:0]       fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;

   logic [2:0]        tail_nbytes;
   logic [4:0]        tail_rem;
   logic              tail_last;
   logic [7:0]        tail_raw;
   logic [7:0]        tail_byte;

   // The output register may take a new byte when empty or being drained now.
   assign out_free   = !byte_valid || byte_ready;
   assign busy       = (state != ST_IDLE);
   assign capture_en = (state != ST_IDLE);
   assign fifo_push  = capture_en && data_ready;

   // Tail formatting: ceil(N/8) bytes, last one padded with 1s below the valid bits.
   assign tail_nbytes = {1'b0, tail_n[4:3]} + {2'b00, |tail_n[2:0]};
   assign tail_rem    = tail_n - {tail_idx[1:0], 3'b000};
   assign tail_last   = ((tail_idx + 3'd1) == tail_nbytes);
   assign tail_raw    = word_byte(tail_word, tail_idx[1:0]);
   assign tail_byte   = tail_last ? tail_pad(tail_raw, tail_rem) : tail_raw;

   jpeg_word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc),
      .push  (fifo_push),
      .wdata (JPEG_bitstream),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state logic: each state decides which byte (if any) loads the output register.
   always_comb begin
      state_nx      = state;
      hdr_addr_nx   = hdr_addr;
      sel_nx        = sel;
      tail_idx_nx   = tail_idx;
      stuff_pend_nx = stuff_pend;
      d9_nx         = d9_loaded;
      done_nx       = 1'b0;
      load          = 1'b0;
      load_byte     = STUFF_00;
      pop           = 1'b0;
      start_acc     = 1'b0;

      case (state)
         ST_IDLE: begin
            // Byte 0 is loaded on the start cycle so it is valid one cycle later.
            if (start) begin
               start_acc = 1'b1;
               load      = 1'b1;
               load_byte = hdr_data;
               if (hdr_addr == HDR_LAST) begin
                  state_nx    = ST_STREAM;
                  hdr_addr_nx = '0;
               end else begin
                  state_nx    = ST_HEADER;
                  hdr_addr_nx = hdr_addr + 1'b1;
               end
            end
         end

         ST_HEADER: begin
            if (out_free) begin
               load      = 1'b1;
               load_byte = hdr_data;
               if (hdr_addr == HDR_LAST) begin
                  state_nx    = ST_STREAM;
                  hdr_addr_nx = '0;
               end else begin
                  hdr_addr_nx = hdr_addr + 1'b1;
               end
            end
         end

         ST_STREAM: begin
            if (out_free) begin
               if (sel != 2'd0) begin
                  load      = 1'b1;
                  load_byte = word_byte(cur_word, sel);
                  sel_nx    = sel + 2'd1;
               end else if (!fifo_empty) begin
                  load      = 1'b1;
                  load_byte = fifo_rdata[31:24];
                  pop       = 1'b1;
                  sel_nx    = 2'd1;
               end else if (eof_seen) begin
                  state_nx      = ST_TAIL;
                  tail_idx_nx   = 3'd0;
                  stuff_pend_nx = 1'b0;
               end
            end
         end

         ST_TAIL: begin
            if (out_free) begin
               if (tail_idx != tail_nbytes) begin
                  load        = 1'b1;
                  load_byte   = tail_byte;
                  tail_idx_nx = tail_idx + 3'd1;
                  if (tail_last && (tail_byte == MRK_FF)) stuff_pend_nx = 1'b1;
               end else if (stuff_pend) begin
                  load          = 1'b1;
                  load_byte     = STUFF_00;
                  stuff_pend_nx = 1'b0;
               end else begin
                  state_nx = ST_EOI_FF;
               end
            end
         end

         ST_EOI_FF: begin
            if (out_free) begin
               load      = 1'b1;
               load_byte = MRK_FF;
               state_nx  = ST_EOI_D9;
               d9_nx     = 1'b0;
            end
         end

         ST_EOI_D9: begin
            // Load 0xD9 once, then finish when the sink takes it.
            if (!d9_loaded) begin
               if (out_free) begin
                  load      = 1'b1;
                  load_byte = MRK_EOI;
                  d9_nx     = 1'b1;
               end
            end else if (byte_ready) begin
               state_nx = ST_IDLE;
               d9_nx    = 1'b0;
               done_nx  = 1'b1;
            end
         end

         default: state_nx = ST_IDLE;
      endcase
   end

   // State register plus the per-section counters and the word being sliced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         hdr_addr   <= '0;
         sel        <= 2'd0;
         tail_idx   <= 3'd0;
         stuff_pend <= 1'b0;
         d9_loaded  <= 1'b0;
         done       <= 1'b0;
         cur_word   <= '0;
      end else begin
         state      <= state_nx;
         hdr_addr   <= hdr_addr_nx;
         sel        <= sel_nx;
         tail_idx   <= tail_idx_nx;
         stuff_pend <= stuff_pend_nx;
         d9_loaded  <= d9_nx;
         done       <= done_nx;
         if (pop) cur_word <= fifo_rdata;
      end
   end

   // Registered byte port: hold until accepted, drop valid only after a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_out   <= STUFF_00;
         byte_valid <= 1'b0;
      end else if (load) begin
         byte_out   <= load_byte;
         byte_valid <= 1'b1;
      end else if (byte_ready) begin
         byte_valid <= 1'b0;
      end
   end

   // Capture path: tail word/count latch and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail_word <= '0;
         tail_n    <= 5'd0;
         eof_seen  <= 1'b0;
         overflow  <= 1'b0;
      end else if (start_acc) begin
         eof_seen <= 1'b0;
         overflow <= 1'b0;
      end else if (capture_en) begin
         if (eof_data_partial_ready) begin
            tail_word <= JPEG_bitstream;
            tail_n    <= end_of_file_bitstream_count;
            eof_seen  <= 1'b1;
         end
         if (data_ready && fifo_full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jpeg_stream_ctrl.sv
// Randomized self-checking bench for jpeg_stream_ctrl against a byte-queue model.
module tb_jpeg_stream_ctrl;

   localparam int FIFO_DEPTH = 8;
   localparam int HDR_LEN    = 4;
   localparam int HDR_AW     = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       JPEG_bitstream = '0;
   logic              data_ready = 1'b0;
   logic              eof_data_partial_ready = 1'b0;
   logic [4:0]        end_of_file_bitstream_count = '0;
   logic [HDR_AW-1:0] hdr_addr;
   logic [7:0]        hdr_data;
   logic [7:0]        byte_out;
   logic              byte_valid;
   logic              byte_ready = 1'b0;
   logic              busy;
   logic              done;
   logic              overflow;

   logic [7:0] rom [16];
   assign hdr_data = rom[hdr_addr];

   jpeg_stream_ctrl #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .HDR_LEN   (HDR_LEN),
      .HDR_AW    (HDR_AW)
   ) dut (
      .clk                         (clk),
      .rst                         (rst),
      .start                       (start),
      .JPEG_bitstream              (JPEG_bitstream),
      .data_ready                  (data_ready),
      .eof_data_partial_ready      (eof_data_partial_ready),
      .end_of_file_bitstream_count (end_of_file_bitstream_count),
      .hdr_addr                    (hdr_addr),
      .hdr_data                    (hdr_data),
      .byte_out                    (byte_out),
      .byte_valid                  (byte_valid),
      .byte_ready                  (byte_ready),
      .busy                        (busy),
      .done                        (done),
      .overflow                    (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Monitor state (sampled on the falling edge, away from the active edge)
   int         cyc = 0;
   logic [7:0] got[$];
   int         last_xfer_cyc;
   int         done_cyc;
   int         done_cnt;
   int         stall_err;
   int         done_busy_err;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_byte = '0;

   // Image description consumed by run_image
   logic [31:0] img_words[$];
   logic [31:0] img_tail;
   logic [4:0]  img_n;
   int          img_eof_gap;
   int          img_rmode;
   bit          img_spaced;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!byte_valid || byte_out != prev_byte)) stall_err++;
         if (byte_valid && byte_ready) begin
            got.push_back(byte_out);
            last_xfer_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy_err++;
         end
         prev_stall = byte_valid && !byte_ready;
         prev_byte  = byte_out;
      end
   end

   task automatic run_image(input string tag, input int keep, input bit exp_ovf);
      int          push_at[$];
      int          t;
      int          eof_at;
      int          k;
      int          nb;
      int          mism;
      logic [31:0] p;
      logic [7:0]  exp_q[$];

      t = 1;
      foreach (img_words[i]) begin
         push_at.push_back(t);
         t += img_spaced ? int'($urandom_range(1, 6)) : 1;
      end
      if (img_words.size() > 0) begin
         eof_at = push_at[$] + img_eof_gap;
         if (img_eof_gap == 0) img_tail = img_words[$];
      end else begin
         eof_at = 1 + img_eof_gap;
      end

      // Reference: header, kept words MSB first, tail bits with 1-fill, stuff, EOI.
      for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(rom[i]);
      for (int i = 0; i < keep; i++)
         for (int j = 0; j < 4; j++) exp_q.push_back(8'(img_words[i] >> (24 - 8 * j)));
      p  = img_tail | (32'hFFFF_FFFF >> img_n);
      nb = (int'(img_n) + 7) / 8;
      for (int i = 0; i < nb; i++) exp_q.push_back(8'(p >> (24 - 8 * i)));
      if (nb > 0 && exp_q[$] == 8'hFF) exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD9);

      got.delete();
      done_cnt = 0; stall_err = 0; done_busy_err = 0;
      done_cyc = -1; last_xfer_cyc = -100;
      k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(posedge clk); #1;
         start = (k == 0);
         data_ready = 1'b0;
         eof_data_partial_ready = 1'b0;
         end_of_file_bitstream_count = 5'd0;
         JPEG_bitstream = '0;
         foreach (push_at[i])
            if (push_at[i] == k) begin
               data_ready = 1'b1;
               JPEG_bitstream = img_words[i];
            end
         if (k == eof_at) begin
            eof_data_partial_ready = 1'b1;
            end_of_file_bitstream_count = img_n;
            if (!data_ready) JPEG_bitstream = img_tail;
         end
         case (img_rmode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ~k[0];
            2:       byte_ready = 1'($urandom_range(0, 1));
            default: byte_ready = (k >= 30);
         endcase
         k++;
      end
      start = 1'b0; data_ready = 1'b0; eof_data_partial_ready = 1'b0;
      end_of_file_bitstream_count = 5'd0; byte_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      checks++;
      if (done_cnt == 0) $display("FAIL %s done_timeout: no done within %0d cycles", tag, k);
      else passes++;

      mism = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) begin mism = i; break; end
      checks++;
      if (got.size() != exp_q.size() || mism >= 0)
         $display("FAIL %s stream: got %0d bytes, need %0d; first diff at %0d (got %h need %h)",
                  tag, got.size(), exp_q.size(), mism,
                  (mism >= 0) ? got[mism] : 8'h00, (mism >= 0) ? exp_q[mism] : 8'h00);
      else passes++;

      checks++;
      if (done_cyc !== last_xfer_cyc + 1)
         $display("FAIL %s done_timing: done at %0d, need %0d", tag, done_cyc, last_xfer_cyc + 1);
      else passes++;

      checks++;
      if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d need 1", tag, done_cnt);
      else passes++;

      checks++;
      if (stall_err !== 0) $display("FAIL %s stall_hold: %0d unstable stalled cycles, need 0", tag, stall_err);
      else passes++;

      checks++;
      if (done_busy_err !== 0) $display("FAIL %s busy_at_done: got %0d cycles busy with done, need 0", tag, done_busy_err);
      else passes++;

      checks++;
      if (overflow !== exp_ovf) $display("FAIL %s overflow: got %b need %b", tag, overflow, exp_ovf);
      else passes++;

      checks++;
      if (busy !== 1'b0 || byte_valid !== 1'b0)
         $display("FAIL %s idle_after: busy=%b valid=%b need 0/0", tag, busy, byte_valid);
      else passes++;
   endtask

   task automatic random_rom();
      for (int i = 0; i < HDR_LEN; i++) rom[i] = 8'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++; if (hdr_addr !== '0) $display("FAIL reset hdr_addr: got %h need 0", hdr_addr); else passes++;
      checks++; if (byte_out !== 8'h00) $display("FAIL reset byte_out: got %h need 00", byte_out); else passes++;
      checks++; if (byte_valid !== 1'b0) $display("FAIL reset byte_valid: got %b need 0", byte_valid); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b need 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset done: got %b need 0", done); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset overflow: got %b need 0", overflow); else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0] lit [14];
      bit ok;
      lit = '{8'hFF, 8'hD8, 8'hAA, 8'hBB, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hFF, 8'hD9};
      rom[0] = 8'hFF; rom[1] = 8'hD8; rom[2] = 8'hAA; rom[3] = 8'hBB;
      img_words = '{32'h1234_5678, 32'h9ABC_DEF0};
      img_tail = 32'h0; img_n = 5'd0; img_eof_gap = 1; img_rmode = 0; img_spaced = 1'b1;
      run_image("basic", 2, 1'b0);
      ok = (got.size() == 14);
      for (int i = 0; i < 14 && ok; i++) if (got[i] !== lit[i]) ok = 1'b0;
      checks++;
      if (!ok) $display("FAIL basic_literal: got %0d bytes %p, need FF D8 AA BB 12 34 56 78 9A BC DE F0 FF D9", got.size(), got);
      else passes++;
   endtask

   task automatic test_tail_stuff();
      random_rom();
      img_words = '{32'($urandom)};
      img_tail = 32'hA5C0_0000; img_n = 5'd10; img_eof_gap = 2; img_rmode = 0; img_spaced = 1'b1;
      run_image("tail_stuff", 1, 1'b0);
      checks++;
      if (got.size() < 5 || got[got.size()-5] !== 8'hA5 || got[got.size()-4] !== 8'hFF ||
          got[got.size()-3] !== 8'h00 || got[got.size()-2] !== 8'hFF || got[got.size()-1] !== 8'hD9)
         $display("FAIL tail_stuff_literal: got %p, need ending A5 FF 00 FF D9", got);
      else passes++;
   endtask

   task automatic test_tail_nostuff();
      random_rom();
      img_words.delete();
      img_tail = 32'h3C00_0000; img_n = 5'd6; img_eof_gap = 1; img_rmode = 0; img_spaced = 1'b1;
      run_image("tail_nostuff", 0, 1'b0);
      checks++;
      if (got.size() != HDR_LEN + 3 || got[HDR_LEN] !== 8'h3F || got[HDR_LEN+1] !== 8'hFF || got[HDR_LEN+2] !== 8'hD9)
         $display("FAIL tail_nostuff_literal: got %p, need header then 3F FF D9", got);
      else passes++;
   endtask

   task automatic test_backpressure();
      random_rom();
      img_words.delete();
      for (int i = 0; i < 5; i++) img_words.push_back($urandom);
      img_tail = $urandom; img_n = 5'($urandom_range(1, 31)); img_eof_gap = 1;
      img_rmode = 1; img_spaced = 1'b1;
      run_image("toggle_ready", 5, 1'b0);
   endtask

   task automatic test_overflow();
      random_rom();
      img_words.delete();
      for (int i = 0; i < 9; i++) img_words.push_back($urandom);
      img_tail = $urandom; img_n = 5'($urandom_range(0, 31)); img_eof_gap = 1;
      img_rmode = 3; img_spaced = 1'b0;
      run_image("overflow", FIFO_DEPTH, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 8; it++) begin
         random_rom();
         img_words.delete();
         for (int i = 0; i < int'($urandom_range(0, FIFO_DEPTH)); i++) img_words.push_back($urandom);
         img_tail = $urandom; img_n = 5'($urandom_range(0, 31));
         img_eof_gap = int'($urandom_range(0, 2));
         img_rmode = int'($urandom_range(0, 2)); img_spaced = 1'b1;
         run_image($sformatf("random%0d", it), img_words.size(), 1'b0);
      end
   endtask

   task automatic test_mid_reset();
      random_rom();
      @(posedge clk); #1;
      start = 1'b1; byte_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         data_ready = 1'b1; JPEG_bitstream = $urandom;
         @(posedge clk); #1;
      end
      data_ready = 1'b0;
      checks++; if (overflow !== 1'b1) $display("FAIL midrst_ovf_set: got %b need 1", overflow); else passes++;
      byte_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b need 1", busy); else passes++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || hdr_addr !== '0)
         $display("FAIL midrst_async: valid=%b busy=%b ovf=%b addr=%h need 0 0 0 0", byte_valid, busy, overflow, hdr_addr);
      else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      img_words = '{32'($urandom), 32'($urandom)};
      img_tail = $urandom; img_n = 5'($urandom_range(0, 31)); img_eof_gap = 1;
      img_rmode = 0; img_spaced = 1'b1;
      run_image("after_reset", 2, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      test_reset();
      test_basic();
      test_tail_stuff();
      test_tail_nostuff();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/jpeg_stream_ctrl.md
# jpeg_stream_ctrl

Output-stage sequencer that turns the 32-bit, already byte-stuffed word stream from `jpeg_top` into a complete JPEG byte stream. It emits a header from an external ROM, drains buffered bitstream words MSB-first, and pads and stuffs the final partial word. It then appends the EOI marker and presents everything on a single valid/ready byte port. It sits between `jpeg_top` and the system byte sink, absorbing sink backpressure that `jpeg_top` cannot tolerate.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: word FIFO depth, power of two, minimum 2.
- `HDR_LEN`, default 623: number of header bytes, SOI included, minimum 1.
- `HDR_AW`, default 10: header address width; requires 2^HDR_AW ≥ HDR_LEN.

Ports:
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin an image; sampled only in IDLE.
- `JPEG_bitstream` input, 32 bits: word from `jpeg_top`, MSB-aligned.
- `data_ready` input, 1 bit: full-word strobe.
- `eof_data_partial_ready` input, 1 bit: final-word strobe.
- `end_of_file_bitstream_count` input, 5 bits: valid bits in the final word.
- `hdr_addr` output, HDR_AW bits: header ROM address.
- `hdr_data` input, 8 bits: ROM byte, combinational from `hdr_addr`.
- `byte_out` output, 8 bits: stream byte.
- `byte_valid` output, 1 bit: `byte_out` is valid.
- `byte_ready` input, 1 bit: sink accepts the byte.
- `busy` output, 1 bit: high whenever the controller is not in IDLE.
- `done` output, 1 bit: one-cycle pulse after the EOI low byte is accepted.
- `overflow` output, 1 bit: sticky flag, a word was dropped because the FIFO was full.

## Operation
- Capture path runs in every state except IDLE:
  - `data_ready` pushes `JPEG_bitstream` into the FIFO.
  - `eof_data_partial_ready` latches the tail word, latches the count N, and sets `eof_seen`.
  - Upstream contract: exactly one partial strobe per image; N=0 means no residual bits.
  - Push while full: the word is dropped and `overflow` is set. `overflow` clears on the next accepted `start`.
- FSM states: IDLE, HEADER, STREAM, TAIL, EOI_FF, EOI_D9.
- **IDLE → HEADER** on `start`. `hdr_addr` is reset to 0.
- **HEADER**:
  - Emits `hdr_data` for addresses 0 to HDR_LEN-1.
  - `hdr_addr` increments on each accepted byte.
  - Moves to STREAM after byte HDR_LEN-1 is accepted.
- **STREAM**:
  - Pops one word and emits bytes [31:24], [23:16], [15:8], [7:0] in that order.
  - No further stuffing is done here; `ff_checker` has already stuffed these words.
  - Moves to TAIL when the FIFO is empty, `eof_seen` is set, and no word is partially sent.
- **TAIL**:
  - Emits ceil(N/8) bytes from the MSB of the tail word.
  - Invalid low bits of the last byte are forced to 1.
  - If that padded byte is 0xFF, an extra 0x00 follows it.
  - With N=0, TAIL emits nothing and moves directly to EOI_FF.
- **EOI_FF** emits 0xFF. **EOI_D9** emits 0xD9, then the FSM returns to IDLE and pulses `done`.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `hdr_addr`=0, `byte_out`=0x00, `byte_valid`=0, `busy`=0, `done`=0, `overflow`=0. FIFO empty, `eof_seen`=0, state IDLE.
- Handshake:
  - A transfer occurs on a cycle with `byte_valid && byte_ready`.
  - `byte_out` holds stable until accepted.
  - `byte_valid` never drops without a transfer.
- `byte_out` and `byte_valid` are registered.
  - First header byte: `byte_valid`=1 in the cycle after `start` is sampled.
  - With `byte_ready` held high, one byte per cycle.
  - No bubbles across state boundaries while the FIFO is non-empty.
- A FIFO word is popped in the cycle its first byte loads into the output register. Push and pop in the same cycle, with the FIFO full, is legal and not an overflow.
- If `data_ready` and `eof_data_partial_ready` arrive in the same cycle, the full word is ordered before the tail.
- `done` asserts in the cycle after the 0xD9 transfer; `busy` falls in that same cycle.
- Asynchronous reset mid-image: immediate return to reset values. Partial output is abandoned and no EOI is emitted.

## Structure
- Package `jpeg_out_pkg`:
  - State enum `jpeg_out_state_t`.
  - Marker constants `MRK_FF`=8'hFF, `MRK_EOI`=8'hD9, `STUFF_00`=8'h00.
- Sub-module `jpeg_word_fifo`: synchronous 32-bit FIFO with full/empty flags, depth FIFO_DEPTH.
- Top-level FSM, byte-select counter, and tail formatter live in `jpeg_stream_ctrl`.

## Test plan
- HDR_LEN=4 ROM {FF,D8,AA,BB}; words 0x12345678 and 0x9ABCDEF0; N=0; `byte_ready`=1.
  - Required: FF D8 AA BB 12 34 56 78 9A BC DE F0 FF D9.
  - `done` 1 cycle after the D9 transfer.
- Tail 0xA5C00000, N=10.
  - Required tail bytes: A5 FF, then 00 (stuff), then FF D9.
- Tail 0x3C000000, N=6.
  - Required tail byte 0x3F with no stuff byte.
- `byte_ready` toggled 1/0 every cycle during STREAM.
  - Required: `byte_out` stable while stalled and the byte sequence unchanged.
- `byte_ready`=0 with 9 `data_ready` strobes and FIFO_DEPTH=8.
  - Required: `overflow`=1 and the 9th word absent from the stream.
- `rst` asserted mid-STREAM, then a new `start`.
  - Required: `byte_valid`=0 immediately, the stream restarts at header byte 0, and `overflow` is cleared.
